arbitrated_rom: RTL and testbench

//  Block-RAM ROM shared by gChannels independent readers. A round-robin arbiter grants at most one read per cycle.

---
 rtl/arbitrated_rom.sv | 192 +++++++++++++++++++
 tb/tb_arbitrated_rom.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitrated_rom.sv
`default_nettype none
// ============================================================================
// Module      : arbitrated_rom
// Description : Block-RAM ROM shared by several independent reader channels.
//               A round-robin arbiter grants at most one read per clock. Each
//               channel owns a valid/ready holding register. Out-of-range
//               addresses return zero with a range-error flag. An optional
//               BRAM output register adds one pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitrated_rom #(
  parameter int gAddressWidth = 10,
  parameter int gDataWidth    = 18,
  parameter int gDepth        = 2**gAddressWidth,
  parameter int gChannels     = 4,
  parameter int gOutputReg    = 1,
  parameter logic [gDepth*gDataWidth-1:0] gContent = '0
) (
  input  logic                               iClock,
  input  logic                               iReset,
  input  logic [gChannels-1:0]               iReq,
  input  logic [gChannels*gAddressWidth-1:0] iAddress,
  output logic [gChannels-1:0]               oAck,
  output logic [gChannels-1:0]               oValid,
  input  logic [gChannels-1:0]               iReady,
  output logic [gChannels*gDataWidth-1:0]    oData,
  output logic [gChannels-1:0]               oRangeErr
);

  localparam int CW = (gChannels > 1) ? $clog2(gChannels) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(gChannels - 1);
  localparam int unsigned DEPTH_U = gDepth;
  // Depth widened by one bit so a full power-of-two depth is representable.
  localparam logic [gAddressWidth:0] DEPTH_EXT = DEPTH_U[gAddressWidth:0];

  // ROM image, built at elaboration
  logic [gDataWidth-1:0] rom [gDepth];

  for (genvar n = 0; n < gDepth; n++) begin : g_rom
    assign rom[n] = gContent[n*gDataWidth +: gDataWidth];
  end

  // Arbiter state
  logic [CW-1:0]        ptr_q, ptr_d;
  logic [gChannels-1:0] busy_q, busy_d;

  // Address stage (BRAM address register plus tag)
  logic                     s1_valid_q;
  logic [CW-1:0]            s1_ch_q;
  logic                     s1_err_q;
  logic [gAddressWidth-1:0] addr_q;

  // Per-channel holding registers
  logic [gChannels-1:0]            valid_q;
  logic [gChannels-1:0]            err_q;
  logic [gChannels*gDataWidth-1:0] data_q;

  // Arbitration results
  logic [gChannels-1:0]     elig;
  logic [gChannels-1:0]     ack;
  logic                     grant;
  logic [CW-1:0]            gnt_idx;
  logic [CW-1:0]            probe;
  logic [gAddressWidth-1:0] gnt_addr;
  logic                     gnt_oor;

  // Word and tag presented to the holding registers
  logic                  cap_valid;
  logic [CW-1:0]         cap_ch;
  logic                  cap_err;
  logic [gDataWidth-1:0] cap_data;
  logic [gDataWidth-1:0] rom_word;

  assign rom_word = rom[addr_q];

  // Round-robin search from pointer+1; eligibility masked while in reset
  always_comb begin
    elig     = iReq & ~busy_q & {gChannels{iReset}};
    grant    = 1'b0;
    gnt_idx  = ptr_q;
    probe    = ptr_q;
    ack      = '0;
    gnt_addr = '0;
    for (int i = 1; i <= gChannels; i++) begin
      probe = CW'((int'(ptr_q) + i) % gChannels);
      if (!grant && elig[probe]) begin
        grant   = 1'b1;
        gnt_idx = probe;
      end
    end
    if (grant) begin
      ack[gnt_idx] = 1'b1;
    end
    for (int c = 0; c < gChannels; c++) begin
      if (ack[c]) begin
        gnt_addr = iAddress[c*gAddressWidth +: gAddressWidth];
      end
    end
    gnt_oor = ({1'b0, gnt_addr} >= DEPTH_EXT);
  end

  assign oAck = ack;

  // Next pointer and busy flags; a channel is busy from grant until consumed
  always_comb begin
    ptr_d  = grant ? gnt_idx : ptr_q;
    busy_d = (busy_q | ack) & ~(valid_q & iReady);
  end

  // Arbiter registers; pointer resets to the last channel so channel 0 wins first
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      ptr_q  <= LAST_CH;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end

  // Address stage: out-of-range reads use address 0 and carry the error tag
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_err_q   <= 1'b0;
      addr_q     <= '0;
    end else begin
      s1_valid_q <= grant;
      s1_ch_q    <= gnt_idx;
      s1_err_q   <= gnt_oor;
      addr_q     <= gnt_oor ? '0 : gnt_addr;
    end
  end

  if (gOutputReg != 0) begin : g_out_reg
    logic                  s2_valid_q;
    logic [CW-1:0]         s2_ch_q;
    logic                  s2_err_q;
    logic [gDataWidth-1:0] s2_data_q;

    // BRAM output register stage
    always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
        s2_valid_q <= 1'b0;
        s2_ch_q    <= '0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_ch_q    <= s1_ch_q;
        s2_err_q   <= s1_err_q;
        s2_data_q  <= rom_word;
      end
    end

    assign cap_valid = s2_valid_q;
    assign cap_ch    = s2_ch_q;
    assign cap_err   = s2_err_q;
    assign cap_data  = s2_data_q;
  end else begin : g_no_out_reg
    assign cap_valid = s1_valid_q;
    assign cap_ch    = s1_ch_q;
    assign cap_err   = s1_err_q;
    assign cap_data  = rom_word;
  end

  // Holding registers: capture tagged word, clear valid on consume
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      valid_q <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      for (int c = 0; c < gChannels; c++) begin
        if (cap_valid && (cap_ch == CW'(c))) begin
          valid_q[c]                         <= 1'b1;
          err_q[c]                           <= cap_err;
          data_q[c*gDataWidth +: gDataWidth] <= cap_err ? '0 : cap_data;
        end else if (valid_q[c] && iReady[c]) begin
          valid_q[c] <= 1'b0;
        end
      end
    end
  end

  assign oValid    = valid_q;
  assign oRangeErr = err_q;
  assign oData     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitrated_rom.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitrated_rom
// Description : Scoreboard bench for arbitrated_rom (4 channels, depth 1000,
//               output register on). ROM word n holds n*3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitrated_rom;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 1000;
  localparam int NCH   = 4;

  function automatic logic [DEPTH*DW-1:0] mk_content();
    logic [DEPTH*DW-1:0] v;
    v = '0;
    for (int n = 0; n < DEPTH; n++) v[n*DW +: DW] = DW'(n * 3);
    return v;
  endfunction

  localparam logic [DEPTH*DW-1:0] CONTENT = mk_content();

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    valid;
  logic [NCH-1:0]    ready;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0]    rerr;

  arbitrated_rom #(
    .gAddressWidth(AW),
    .gDataWidth   (DW),
    .gDepth       (DEPTH),
    .gChannels    (NCH),
    .gOutputReg   (1),
    .gContent     (CONTENT)
  ) dut (
    .iClock   (clk),
    .iReset   (rst_n),
    .iReq     (req),
    .iAddress (addr),
    .oAck     (ack),
    .oValid   (valid),
    .iReady   (ready),
    .oData    (data),
    .oRangeErr(rerr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] exp_d [NCH];
  logic          exp_e [NCH];
  int            ack_cnt [NCH];
  int            ack_cyc [NCH];
  int            cons_cyc [NCH];
  int            gnt_log[$];
  bit            log_en = 1'b0;
  logic [NCH-1:0] prev_valid = '0;
  int            valid_rises = 0;
  int            sb_idx;

  // Grant monitor: pushes the expected response for each accepted request
  always @(negedge clk) begin
    chk("ack_onehot", longint'($onehot0(ack)), 1);
    for (int c = 0; c < NCH; c++) begin
      if (ack[c]) begin
        sb.push_back('{ch: 2'(c), d: exp_d[c], e: exp_e[c]});
        ack_cnt[c] = ack_cnt[c] + 1;
        ack_cyc[c] = cyc;
        if (log_en) gnt_log.push_back(c);
      end
    end
  end

  // Result monitor: compares every valid cycle, pops on handshake
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (valid[c]) begin
        if (!prev_valid[c]) begin
          valid_rises = valid_rises + 1;
          chk($sformatf("latency_ch%0d", c), cyc - ack_cyc[c], 3);
        end
        sb_idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (sb_idx < 0 && sb[i].ch == 2'(c)) sb_idx = i;
        if (sb_idx < 0) begin
          chk($sformatf("unexpected_valid_ch%0d", c), 1, 0);
        end else begin
          chk($sformatf("data_ch%0d", c), data[c*DW +: DW], sb[sb_idx].d);
          chk($sformatf("rangeerr_ch%0d", c), rerr[c], sb[sb_idx].e);
          if (ready[c]) begin
            sb.delete(sb_idx);
            cons_cyc[c] = cyc;
          end
        end
      end
      prev_valid[c] = valid[c];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int a, input int d, input logic e);
    addr[c*AW +: AW] = AW'(a);
    exp_d[c]         = DW'(d);
    exp_e[c]         = e;
  endtask

  task automatic wait_ack(input int c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (ack[c]) ok = 1'b1;
    end
    if (!ok) chk($sformatf("ack_timeout_ch%0d", c), 0, 1);
    #1;
  endtask

  task automatic do_read(input int c, input int a, input int d, input logic e);
    set_ch(c, a, d, e);
    req[c] = 1'b1;
    wait_ack(c);
    tick();
    req[c] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    chk("drain_pending", sb.size(), 0);
    tick();
  endtask

  int fair_exp [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
  int n0;
  int vr0;

  initial begin
    rst_n = 1'b0;
    req   = '1;
    ready = '1;
    addr  = '0;
    set_ch(0, 0,   0,   1'b0);
    set_ch(1, 1,   3,   1'b0);
    set_ch(2, 7,   21,  1'b0);
    set_ch(3, 100, 300, 1'b0);
    log_en = 1'b1;

    // Reset held with every channel requesting
    repeat (3) @(negedge clk);
    chk("reset_ack",   ack,   0);
    chk("reset_valid", valid, 0);
    chk("reset_data",  data,  0);
    chk("reset_rerr",  rerr,  0);

    // Release: fair rotation starting at channel 0
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60 && gnt_log.size() < 12; i++) @(negedge clk);
    tick();
    req    = '0;
    log_en = 1'b0;
    chk("fair_count", (gnt_log.size() >= 12) ? 1 : 0, 1);
    for (int i = 0; i < 12 && i < gnt_log.size(); i++)
      chk($sformatf("fair_order_%0d", i), gnt_log[i], fair_exp[i]);
    drain();

    // Latency: channel 2, address 5 -> 15
    do_read(2, 5, 15, 1'b0);
    drain();

    // Backpressure on channel 1
    ready[1] = 1'b0;
    set_ch(1, 10, 30, 1'b0);
    req[1] = 1'b1;
    wait_ack(1);
    n0 = ack_cnt[1];
    repeat (13) tick();
    chk("bp_no_reack", ack_cnt[1], n0);
    chk("bp_valid_held", valid[1], 1);
    ready[1] = 1'b1;
    wait_ack(1);
    chk("bp_reack_gap", ack_cyc[1] - cons_cyc[1], 1);
    tick();
    req[1] = 1'b0;
    drain();

    // Range checking
    do_read(3, 1000, 0,    1'b1);
    do_read(3, 999,  2997, 1'b0);
    do_read(3, 1023, 0,    1'b1);
    do_read(0, 512,  1536, 1'b0);
    drain();

    // Reset while a read is in flight
    set_ch(0, 3, 9, 1'b0);
    req[0] = 1'b1;
    wait_ack(0);
    tick();
    req[0] = 1'b0;
    rst_n  = 1'b0;
    sb.delete();
    vr0 = valid_rises;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("midreset_no_valid", valid_rises, vr0);
    do_read(0, 4, 12, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
